fifo_rd_stream: RTL and testbench
=================================

# fifo_rd_stream

Read-side stream adapter placed directly downstream of the FIFO controller and register file. It pops words from the FIFO whenever it has buffer room and presents them on a valid/ready master stream at one word per cycle, with no combinational path from `m_ready_i` to the FIFO read strobe. A two-entry output/skid buffer sustains full throughput under backpressure.

## Interface
- `DataBits`, default 8: width of FIFO words and stream data.
- `CntBits`, default 16: width of the beat counter; used only with `FIFO_RD_STREAM_STATS_EN`.

Ports:
- `clk_i`  in  1  Clock; all state updates on its rising edge.
- `rst_ni`  in  1  Reset. Asynchronous assertion, active-low.
- `empty_i`  in  1  FIFO empty flag. Registered by the controller.
- `r_data_i`  in  DataBits  Register-file word at the current read address. Combinational, valid in the same cycle.
- `rd_o`  out  1  FIFO read strobe. The controller advances its read pointer on the next edge.
- `flush_i`  in  1  Synchronous flush of the local buffers.
- `m_valid_o`  out  1  Stream valid.
- `m_data_o`  out  DataBits  Stream data.
- `m_ready_i`  in  1  Stream ready.
- `beats_o`  out  CntBits  Delivered-beat count. Present only with `FIFO_RD_STREAM_STATS_EN`.

## Operation
- Buffer state machine with three states: `EMPTY` (no word held), `ONE` (output register valid), `TWO` (output and skid registers both valid).
- Pop condition: `rd_o = rst_ni & ~empty_i & ~flush_i & (state != TWO)`.
  - `rd_o` never depends on `m_ready_i`.
  - `rd_o` is never asserted when `empty_i` is high.
- Handshake: `hs = m_valid_o & m_ready_i`. Pop: `pop = rd_o`. On a pop, `r_data_i` is captured at the same edge.
- Transitions:
  - `EMPTY`, pop: output register ← `r_data_i`, go to `ONE`. No pop: stay.
  - `ONE`:
    - hs & pop: output register ← `r_data_i`, stay `ONE`.
    - hs only: go to `EMPTY`.
    - pop only: skid ← `r_data_i`, go to `TWO`.
    - neither: stay.
  - `TWO`, hs: output register ← skid, go to `ONE`. No hs: stay. No pop is possible in `TWO`.
- Output mapping: `m_valid_o = (state != EMPTY)`. `m_data_o` = output register.
- Hold rule: while `m_valid_o & ~m_ready_i`, `m_data_o` is held stable.
- Ordering: words leave in strict FIFO order. No word is dropped or duplicated unless flushed.
- Flush:
  - `flush_i` high at an edge sends the state to `EMPTY` and discards held words.
  - `rd_o` is 0 in that cycle, so nothing is popped.
  - The stream may show `m_valid_o` high in the flush cycle; a handshake in that cycle still counts as delivered.
- Data registers are not cleared by flush; only the valid state is cleared.

## Timing
- Reset values: state `EMPTY`, `m_valid_o`=0, `m_data_o`=0, skid=0, `beats_o`=0, `rd_o`=0 while `rst_ni` is low.
- Latency: when `empty_i` falls before edge n and the buffer is `EMPTY`, `m_valid_o` rises right after edge n.
- Throughput: one word per cycle with `m_ready_i` held high and the FIFO non-empty.
- Backpressure: `m_ready_i` low for k≥2 cycles absorbs exactly two words. `rd_o` then stays 0 until a handshake occurs.
- Recovery: on the first `m_ready_i` high, the skid word is presented the next cycle. `rd_o` re-asserts in the cycle after that handshake edge, once state is `ONE`.
- FIFO drains to empty while in `ONE` with `m_ready_i` high: the last word is delivered, then the state goes to `EMPTY` with no bubble error.
- Reset mid-transfer: words held locally are lost. The FIFO controller is reset by the same reset.

## Configuration
- `FIFO_RD_STREAM_STATS_EN` defined:
  - `beats_o` exists and increments by 1 on every handshake edge.
  - It wraps from 2^CntBits−1 to 0.
  - It is unaffected by `flush_i`; it clears only on reset.
- Not defined: the `beats_o` port and counter are absent, and all other behaviour is identical.

## Test plan
- Reset release with `empty_i`=1 → `m_valid_o`=0, `rd_o`=0, `m_data_o`=0 for 10 cycles.
- FIFO holds 0x11,0x22,0x33 with `m_ready_i`=1 → `rd_o` high 3 cycles, stream delivers 0x11,0x22,0x33 on consecutive cycles, `beats_o`=3.
- FIFO holds 0xA0..0xA4 with `m_ready_i`=0 for 5 cycles → exactly 2 pops, `m_data_o`=0xA0 stable. After ready rises, order is 0xA0..0xA4 with no gaps after the first beat.
- Random `m_ready_i` with 200 words 0x00..0xC7 → scoreboard matches in order, `rd_o` never high with `empty_i`=1, state never exceeds `TWO`.
- `TWO` state holding 0x5A,0x5B, then `flush_i` pulse → `m_valid_o`=0 next cycle, `rd_o`=0 in the flush cycle, the next delivered word is the FIFO head.
- With stats on and `CntBits`=4, 17 beats → `beats_o`=1 (wrap).

Source files
------------

// File: rtl/fifo_rd_stream_if.sv
// Valid/ready stream carrying words read out of the FIFO.
// The adapter drives it through the master modport; the consumer uses the slave modport.
interface fifo_rd_stream_if #(
  parameter int DataBits = 8
);
  logic                m_valid_o;
  logic [DataBits-1:0] m_data_o;
  logic                m_ready_i;

  modport master (
    output m_valid_o,
    output m_data_o,
    input  m_ready_i
  );

  modport slave (
    input  m_valid_o,
    input  m_data_o,
    output m_ready_i
  );
endinterface

// File: rtl/fifo_rd_stream.sv
// FIFO read-side stream adapter with a two-entry output/skid buffer.
// Optional beat counter beats_o is enabled by defining FIFO_RD_STREAM_STATS_EN.
module fifo_rd_stream #(
  parameter int DataBits = 8,
  parameter int CntBits  = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                empty_i,
  input  logic [DataBits-1:0] r_data_i,
  output logic                rd_o,
  input  logic                flush_i,
  fifo_rd_stream_if.master    m
`ifdef FIFO_RD_STREAM_STATS_EN
  ,
  output logic [CntBits-1:0]  beats_o
`endif
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  logic [1:0]          state_reg, state_next;
  logic [DataBits-1:0] out_reg, out_next;
  logic [DataBits-1:0] skid_reg, skid_next;
  logic                hs;

  // The read strobe looks only at local state, never at m_ready_i.
  assign rd_o        = rst_ni & ~empty_i & ~flush_i & (state_reg != TWO);
  assign m.m_valid_o = (state_reg != EMPTY);
  assign m.m_data_o  = out_reg;
  assign hs          = m.m_valid_o & m.m_ready_i;

  always_comb begin
    state_next = state_reg;
    out_next   = out_reg;
    skid_next  = skid_reg;
    case (state_reg)
      EMPTY: begin
        if (rd_o) begin
          out_next   = r_data_i;
          state_next = ONE;
        end
      end
      ONE: begin
        if (hs && rd_o) begin
          out_next = r_data_i;
        end else if (hs) begin
          state_next = EMPTY;
        end else if (rd_o) begin
          skid_next  = r_data_i;
          state_next = TWO;
        end
      end
      TWO: begin
        if (hs) begin
          out_next   = skid_reg;
          state_next = ONE;
        end
      end
      default: state_next = EMPTY;
    endcase
    // Flush drops held words but leaves the data registers untouched.
    if (flush_i) begin
      state_next = EMPTY;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= EMPTY;
      out_reg   <= '0;
      skid_reg  <= '0;
    end else begin
      state_reg <= state_next;
      out_reg   <= out_next;
      skid_reg  <= skid_next;
    end
  end

`ifdef FIFO_RD_STREAM_STATS_EN
  logic [CntBits-1:0] beats_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      beats_reg <= '0;
    end else if (hs) begin
      beats_reg <= beats_reg + 1'b1;
    end
  end

  assign beats_o = beats_reg;
`else
  wire [CntBits-1:0] unused_cnt_bits = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Self-checking bench for fifo_rd_stream: behavioural FIFO model, scoreboard and a
// table-driven backpressure sequence.
module tb_fifo_rd_stream;
  localparam int DW = 8;
  localparam int CB = 4;

  logic          clk_i    = 1'b0;
  logic          rst_ni   = 1'b0;
  logic          empty_i  = 1'b1;
  logic [DW-1:0] r_data_i = '0;
  logic          flush_i  = 1'b0;
  logic          rd_o;
`ifdef FIFO_RD_STREAM_STATS_EN
  logic [CB-1:0] beats_o;
`endif

  fifo_rd_stream_if #(.DataBits(DW)) s_if ();

  fifo_rd_stream #(
    .DataBits(DW),
    .CntBits (CB)
  ) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .empty_i (empty_i),
    .r_data_i(r_data_i),
    .rd_o    (rd_o),
    .flush_i (flush_i),
    .m       (s_if)
`ifdef FIFO_RD_STREAM_STATS_EN
    ,
    .beats_o (beats_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  int            held = 0;
  int            pops = 0;
  logic [CB-1:0] beats_exp = '0;
  logic          last_hs, last_rd, last_valid;
  logic [DW-1:0] last_data;

  typedef struct {
    logic          ready;
    logic          exp_rd;
    logic          exp_valid;
    logic [DW-1:0] exp_data;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic refresh_fifo();
    empty_i = (fifo_q.size() == 0);
    if (fifo_q.size() != 0) r_data_i = fifo_q[0];
    else r_data_i = '0;
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
    refresh_fifo();
  endtask

  // One clock: sample and check before the edge, update the models after it.
  task automatic step();
    logic          p, h;
    logic [DW-1:0] d, e;
    @(negedge clk_i);
    p = rd_o;
    h = s_if.m_valid_o & s_if.m_ready_i;
    d = s_if.m_data_o;
    chk("rd_while_empty", {31'd0, p & empty_i}, 32'd0);
    chk("valid_vs_occupancy", {31'd0, s_if.m_valid_o}, {31'd0, held != 0});
    chk("occupancy_max", {31'd0, held > 2}, 32'd0);
    if (flush_i) chk("rd_in_flush", {31'd0, p}, 32'd0);
`ifdef FIFO_RD_STREAM_STATS_EN
    chk("beats", {28'd0, beats_o}, {28'd0, beats_exp});
`endif
    if (h) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_data", {24'd0, d}, {24'd0, e});
      end
      held--;
    end
    last_hs    = h;
    last_rd    = p;
    last_valid = s_if.m_valid_o;
    last_data  = d;
    @(posedge clk_i);
    if (p && fifo_q.size() != 0) begin
      void'(fifo_q.pop_front());
      held++;
      pops++;
    end
    if (h) beats_exp = beats_exp + 1'b1;
    if (flush_i) begin
      for (int i = 0; i < held; i++) begin
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      held = 0;
    end
    #1;
    refresh_fifo();
  endtask

  task automatic do_reset();
    rst_ni            = 1'b0;
    flush_i           = 1'b0;
    s_if.m_ready_i    = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    held      = 0;
    pops      = 0;
    beats_exp = '0;
    // Non-empty FIFO during reset must still not be popped.
    empty_i  = 1'b0;
    r_data_i = 8'h77;
    @(negedge clk_i);
    chk("reset_rd", {31'd0, rd_o}, 32'd0);
    chk("reset_valid", {31'd0, s_if.m_valid_o}, 32'd0);
    chk("reset_data", {24'd0, s_if.m_data_o}, 32'd0);
    @(posedge clk_i);
    #1;
    refresh_fifo();
    rst_ni = 1'b1;
  endtask

  vec_t vecs[11];

  initial begin
    int            first_hs, last_hs_idx, n;
    logic [DW-1:0] first_word;
    logic          prev_stall;
    logic [DW-1:0] prev_data;

    // Backpressure sequence, FIFO preloaded with A0..A4, ready low for 5 cycles.
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 8'h00};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 8'hA0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 8'hA0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 8'hA0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 8'hA0};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 8'hA0};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 8'hA1};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 8'hA2};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 8'hA3};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 8'hA4};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 8'hA4};

    s_if.m_ready_i = 1'b0;

    // Idle after reset with an empty FIFO.
    do_reset();
    s_if.m_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_valid", {31'd0, last_valid}, 32'd0);
      chk("idle_rd", {31'd0, last_rd}, 32'd0);
      chk("idle_data", {24'd0, last_data}, 32'd0);
    end

    // Back-to-back burst with ready held high.
    do_reset();
    push_word(8'h11);
    push_word(8'h22);
    push_word(8'h33);
    s_if.m_ready_i = 1'b1;
    first_hs = -1;
    last_hs_idx = -1;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      step();
      if (last_hs) begin
        if (first_hs < 0) first_hs = n;
        last_hs_idx = n;
      end
      n++;
    end
    chk("burst_drained", exp_q.size(), 32'd0);
    chk("burst_latency", first_hs, 32'd1);
    chk("burst_consecutive", last_hs_idx - first_hs, 32'd2);
    chk("burst_pops", pops, 32'd3);
`ifdef FIFO_RD_STREAM_STATS_EN
    chk("burst_beats", {28'd0, beats_o}, 32'd3);
`endif

    // Table-driven backpressure and recovery.
    do_reset();
    for (int i = 0; i < 5; i++) push_word(8'hA0 + 8'(i));
    for (int i = 0; i < 11; i++) begin
      s_if.m_ready_i = vecs[i].ready;
      step();
      chk($sformatf("bp_rd[%0d]", i), {31'd0, last_rd}, {31'd0, vecs[i].exp_rd});
      chk($sformatf("bp_valid[%0d]", i), {31'd0, last_valid}, {31'd0, vecs[i].exp_valid});
      chk($sformatf("bp_data[%0d]", i), {24'd0, last_data}, {24'd0, vecs[i].exp_data});
    end
    chk("bp_pops", pops, 32'd5);

    // Random backpressure over 200 words.
    do_reset();
    for (int i = 0; i < 200; i++) push_word(8'(i));
    prev_stall = 1'b0;
    prev_data  = '0;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      s_if.m_ready_i = 1'($urandom_range(0, 1));
      step();
      if (prev_stall) chk("hold_stable", {24'd0, last_data}, {24'd0, prev_data});
      prev_stall = last_valid & ~s_if.m_ready_i;
      prev_data  = last_data;
      n++;
    end
    chk("random_drained", exp_q.size(), 32'd0);
    chk("random_pops", pops, 32'd200);

    // Flush while holding two words.
    do_reset();
    push_word(8'h5A);
    push_word(8'h5B);
    push_word(8'h5C);
    s_if.m_ready_i = 1'b0;
    step();
    step();
    flush_i = 1'b1;
    step();
    chk("flush_rd", {31'd0, last_rd}, 32'd0);
    chk("flush_valid_in_cycle", {31'd0, last_valid}, 32'd1);
    chk("flush_data_in_cycle", {24'd0, last_data}, 32'h5A);
    flush_i = 1'b0;
    step();
    chk("flush_valid_after", {31'd0, last_valid}, 32'd0);
    chk("flush_rd_after", {31'd0, last_rd}, 32'd1);
    s_if.m_ready_i = 1'b1;
    first_word = '0;
    n = 0;
    while (exp_q.size() != 0 && n < 10) begin
      step();
      if (last_hs && n == 0) first_word = last_data;
      if (last_hs) n = 100;
      else n++;
    end
    chk("flush_head", {24'd0, first_word}, 32'h5C);
    chk("flush_drained", exp_q.size(), 32'd0);

`ifdef FIFO_RD_STREAM_STATS_EN
    // Counter wrap: 17 beats on a 4-bit counter.
    do_reset();
    for (int i = 0; i < 17; i++) push_word(8'hC0 + 8'(i));
    s_if.m_ready_i = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      step();
      n++;
    end
    chk("wrap_drained", exp_q.size(), 32'd0);
    chk("beats_wrap", {28'd0, beats_o}, 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
